// File: rtl/weighted_batch_rr_arbiter_if.sv
// Handshake bundle between the user TX channels, the batch arbiter and the
// shared TX channel. The user/downstream side drives through "master"; the
// arbiter connects through "slave".
interface weighted_batch_rr_arbiter_if #(
    parameter int NUMBER_OF_USERS = 4,
    parameter int USERS_BITS      = 2,
    parameter int USER_LINE_WIDTH = 512
);
    logic [USER_LINE_WIDTH-1:0] usr_tx_lines [NUMBER_OF_USERS];
    logic [NUMBER_OF_USERS-1:0] usr_tx_valid;
    logic [NUMBER_OF_USERS-1:0] usr_tx_last;
    logic [NUMBER_OF_USERS-1:0] usr_tx_ready;
    logic [USER_LINE_WIDTH-1:0] rr_tx_line;
    logic [USERS_BITS-1:0]      rr_tx_tag;
    logic                       rr_tx_last;
    logic                       rr_tx_valid;
    logic                       rr_tx_ready;

    modport master (
        output usr_tx_lines, usr_tx_valid, usr_tx_last, rr_tx_ready,
        input  usr_tx_ready, rr_tx_line, rr_tx_tag, rr_tx_last, rr_tx_valid
    );

    modport slave (
        input  usr_tx_lines, usr_tx_valid, usr_tx_last, rr_tx_ready,
        output usr_tx_ready, rr_tx_line, rr_tx_tag, rr_tx_last, rr_tx_valid
    );
endinterface

// File: rtl/weighted_batch_rr_arbiter.sv
// Weighted batch round-robin arbiter for the fthread shell TX path.
// A grantee keeps the grant for its configured number of beats, never loses
// it mid-packet, and beats leave through a single registered output entry.
module weighted_batch_rr_arbiter #(
    parameter int NUMBER_OF_USERS = 4,
    parameter int USERS_BITS      = 2,
    parameter int USER_LINE_WIDTH = 512,
    parameter int BATCH_BITS      = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUMBER_OF_USERS*BATCH_BITS-1:0] cfg_batch_size,
    input  logic [NUMBER_OF_USERS-1:0]            cfg_user_enable,
    weighted_batch_rr_arbiter_if.slave            bus
);
    localparam logic [0:0]            IDLE      = 1'b0;
    localparam logic [0:0]            BATCH     = 1'b1;
    localparam logic [BATCH_BITS-1:0] COUNT_MAX = {BATCH_BITS{1'b1}};
    localparam logic [BATCH_BITS-1:0] COUNT_ONE = BATCH_BITS'(1);
    localparam logic [USERS_BITS-1:0] LAST_USER = USERS_BITS'(NUMBER_OF_USERS - 1);

    logic [0:0]                 state;
    logic [USERS_BITS-1:0]      owner;
    logic [USERS_BITS-1:0]      last_owner;
    logic [BATCH_BITS-1:0]      count;
    logic [BATCH_BITS-1:0]      eff_batch;
    logic                       in_pkt;

    logic [USER_LINE_WIDTH-1:0] line_p1;
    logic [USERS_BITS-1:0]      tag_p1;
    logic                       last_p1;
    logic                       vld_p1;

    logic [NUMBER_OF_USERS-1:0] elig;
    logic                       can_load;
    logic [USERS_BITS-1:0]      cand;
    logic [USERS_BITS-1:0]      idle_pick;
    logic                       idle_found;
    logic [USERS_BITS-1:0]      grantee;
    logic                       grant_ok;
    logic [NUMBER_OF_USERS-1:0] usr_ready;
    logic                       accept;
    logic                       acc_last;
    logic [BATCH_BITS-1:0]      batch_sel;
    logic [BATCH_BITS-1:0]      eff_next;
    logic [BATCH_BITS-1:0]      count_next;
    logic                       release_full;
    logic                       release_idle;

    assign elig     = bus.usr_tx_valid & cfg_user_enable;
    assign can_load = ~vld_p1 | bus.rr_tx_ready;

    // Circular search from last_owner+1; the lowest distance wins, so the
    // previous owner is always considered last.
    always_comb begin
        cand       = '0;
        idle_pick  = last_owner;
        idle_found = 1'b0;
        for (int k = NUMBER_OF_USERS; k >= 1; k--) begin
            cand = USERS_BITS'((int'(last_owner) + k) % NUMBER_OF_USERS);
            if (elig[cand]) begin
                idle_pick  = cand;
                idle_found = 1'b1;
            end
        end
    end

    // Grant decode: in BATCH the owner stays ready regardless of its valid, but
    // a disabled owner is cut off once it is at a packet boundary.
    always_comb begin
        grantee   = owner;
        grant_ok  = in_pkt | cfg_user_enable[owner];
        usr_ready = '0;
        if (state == IDLE) begin
            grantee  = idle_pick;
            grant_ok = idle_found;
        end
        if (grant_ok && can_load) begin
            usr_ready[grantee] = 1'b1;
        end
    end

    assign bus.usr_tx_ready = usr_ready;
    assign accept           = |(bus.usr_tx_valid & usr_ready);
    assign acc_last         = bus.usr_tx_last[grantee];
    assign batch_sel        = cfg_batch_size[int'(grantee)*BATCH_BITS +: BATCH_BITS];
    assign eff_next         = (state == IDLE) ? ((batch_sel == '0) ? COUNT_ONE : batch_sel)
                                              : eff_batch;
    assign count_next       = (state == IDLE) ? COUNT_ONE
                                              : ((count == COUNT_MAX) ? count : count + COUNT_ONE);
    assign release_full     = accept & acc_last & (count_next >= eff_next);
    assign release_idle     = ~in_pkt & ~elig[owner];

    // Grant FSM: commit a new owner on its first accepted beat, release on a
    // completed batch at a packet end or when the owner goes idle between packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_USER;
            count      <= '0;
            eff_batch  <= '0;
            in_pkt     <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                owner      <= grantee;
                last_owner <= grantee;
                count      <= COUNT_ONE;
                eff_batch  <= eff_next;
                in_pkt     <= ~acc_last;
                state      <= release_full ? IDLE : BATCH;
            end
        end else begin
            if (accept) begin
                count  <= count_next;
                in_pkt <= ~acc_last;
            end
            if (release_full || release_idle) begin
                state <= IDLE;
            end
        end
    end

    // Output entry: load on every accepted beat, drain when downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_p1 <= '0;
            tag_p1  <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (accept) begin
            line_p1 <= bus.usr_tx_lines[grantee];
            tag_p1  <= grantee;
            last_p1 <= acc_last;
            vld_p1  <= 1'b1;
        end else if (bus.rr_tx_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.rr_tx_line  = line_p1;
    assign bus.rr_tx_tag   = tag_p1;
    assign bus.rr_tx_last  = last_p1;
    assign bus.rr_tx_valid = vld_p1;
endmodule

// File: tb/tb_weighted_batch_rr_arbiter.sv
// Testbench for weighted_batch_rr_arbiter: cycle table, hand-written corner
// sequences and randomized packet traffic against a transaction-level model.
module tb_weighted_batch_rr_arbiter;
    localparam int N  = 4;
    localparam int UB = 2;
    localparam int W  = 512;
    localparam int BB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*BB-1:0] cfg_batch_size;
    logic [N-1:0]    cfg_user_enable;

    weighted_batch_rr_arbiter_if #(.NUMBER_OF_USERS(N), .USERS_BITS(UB), .USER_LINE_WIDTH(W)) bus ();

    weighted_batch_rr_arbiter #(
        .NUMBER_OF_USERS(N), .USERS_BITS(UB), .USER_LINE_WIDTH(W), .BATCH_BITS(BB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_batch_size (cfg_batch_size),
        .cfg_user_enable(cfg_user_enable),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle table record
    typedef struct {
        bit          do_reset;
        logic [31:0] batch;
        logic [3:0]  enable;
        logic [3:0]  valid;
        logic        rr_ready;
        logic        exp_vld;
        logic [1:0]  exp_tag;
        logic [3:0]  exp_rdy;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit rs, input logic [31:0] b, input logic [3:0] en,
                                input logic [3:0] v, input logic rr, input logic ev,
                                input logic [1:0] et, input logic [3:0] er);
        vec_t x;
        x.do_reset = rs; x.batch = b; x.enable = en; x.valid = v; x.rr_ready = rr;
        x.exp_vld = ev; x.exp_tag = et; x.exp_rdy = er;
        vecs.push_back(x);
    endfunction

    // Random traffic storage and expected beat order
    typedef struct {
        logic [1:0]  tag;
        logic [63:0] line;
        bit          last;
    } beat_t;
    beat_t       exp_q[$];
    logic [63:0] pk_line [N][64];
    bit          pk_last [N][64];
    int          pk_len  [N];

    // Order of beats implied by the arbitration rules when every user with
    // data keeps it presented continuously; independent of downstream stalls.
    function automatic void build_model(input logic [31:0] batch, input logic [3:0] en);
        int ptr[N];
        int lo;
        int u;
        int cnt;
        int eff;
        bit found;
        beat_t b;
        exp_q.delete();
        foreach (ptr[i]) ptr[i] = 0;
        lo = N - 1;
        u  = 0;
        forever begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                u = (lo + k) % N;
                if (en[u] && ptr[u] < pk_len[u]) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            eff = int'(batch[u*BB +: BB]);
            if (eff == 0) eff = 1;
            cnt = 0;
            forever begin
                b.tag  = 2'(u);
                b.line = pk_line[u][ptr[u]];
                b.last = pk_last[u][ptr[u]];
                exp_q.push_back(b);
                cnt++;
                ptr[u]++;
                if (b.last && (cnt >= eff || ptr[u] == pk_len[u])) break;
            end
            lo = u;
        end
    endfunction

    task automatic set_lines_const();
        for (int u = 0; u < N; u++) bus.usr_tx_lines[u] = W'(u + 1);
    endtask

    // Called and returning at a negedge; inputs idle during reset.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.usr_tx_valid = '0;
        bus.usr_tx_last  = '0;
        bus.rr_tx_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input logic [3:0] v, input logic [3:0] l, input logic rr);
        bus.usr_tx_valid = v;
        bus.usr_tx_last  = l;
        bus.rr_tx_ready  = rr;
        #1;
    endtask

    int          ptr_r [N];
    logic [3:0]  acc;
    bit          hold;
    logic [63:0] hold_line;
    int          cyc;
    int          tail;
    int          b2;
    beat_t       e;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        cfg_batch_size  = 32'h04040404;
        cfg_user_enable = 4'hF;
        bus.usr_tx_valid = '0;
        bus.usr_tx_last  = '0;
        bus.rr_tx_ready  = 1'b0;
        set_lines_const();

        // Segment 1: batch 4, all valid, single-beat packets, downstream always ready
        for (int c = 0; c < 18; c++)
            add(c == 0, 32'h04040404, 4'hF, 4'hF, 1'b1, c >= 1,
                2'(((c - 1) / 4) % 4), 4'(1 << ((c / 4) % 4)));
        // Segment 2: downstream ready toggling, only user 0 valid
        add(1, 32'h04040404, 4'hF, 4'h1, 1, 0, 0, 4'b0001);
        add(0, 32'h04040404, 4'hF, 4'h1, 0, 1, 0, 4'b0000);
        add(0, 32'h04040404, 4'hF, 4'h1, 1, 1, 0, 4'b0001);
        add(0, 32'h04040404, 4'hF, 4'h1, 0, 1, 0, 4'b0000);
        add(0, 32'h04040404, 4'hF, 4'h1, 1, 1, 0, 4'b0001);
        add(0, 32'h04040404, 4'hF, 4'h1, 0, 1, 0, 4'b0000);
        add(0, 32'h04040404, 4'hF, 4'h1, 1, 1, 0, 4'b0001);
        add(0, 32'h04040404, 4'hF, 4'h1, 0, 1, 0, 4'b0000);
        add(0, 32'h04040404, 4'hF, 4'h1, 1, 1, 0, 4'b0001);
        // Segment 3: user 2 disabled, user 1 batch 0 (one beat), others batch 2
        add(1, 32'h02020002, 4'b1011, 4'hF, 1, 0, 0, 4'b0001);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 0, 4'b0001);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 0, 4'b0010);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 1, 4'b1000);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 3, 4'b1000);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 3, 4'b0001);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 0, 4'b0001);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 0, 4'b0010);
        add(0, 32'h02020002, 4'b1011, 4'hF, 1, 1, 1, 4'b1000);

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].do_reset) do_reset();
            cfg_batch_size  = vecs[i].batch;
            cfg_user_enable = vecs[i].enable;
            apply(vecs[i].valid, 4'hF, vecs[i].rr_ready);
            check($sformatf("tbl%0d_vld", i), 64'(bus.rr_tx_valid), 64'(vecs[i].exp_vld));
            check($sformatf("tbl%0d_rdy", i), 64'(bus.usr_tx_ready), 64'(vecs[i].exp_rdy));
            if (vecs[i].exp_vld) begin
                check($sformatf("tbl%0d_tag", i), 64'(bus.rr_tx_tag), 64'(vecs[i].exp_tag));
                check($sformatf("tbl%0d_line", i), bus.rr_tx_line[63:0], 64'(vecs[i].exp_tag) + 64'd1);
            end
            @(negedge clk);
        end

        // Packet lock: user 2 sends a 5-beat packet with batch 2 and stalls mid-packet
        cfg_batch_size  = 32'h02020202;
        cfg_user_enable = 4'hF;
        do_reset();
        check("rst_tag", 64'(bus.rr_tx_tag), 64'd0);
        check("rst_line", bus.rr_tx_line[63:0], 64'd0);
        check("rst_last", 64'(bus.rr_tx_last), 64'd0);
        check("rst_vld", 64'(bus.rr_tx_valid), 64'd0);
        b2 = 0;
        for (int c = 0; c < 9; c++) begin
            if (c >= 2 && c <= 4) apply(4'b1001, 4'b0000, 1'b1);
            else if (c < 2) apply(4'b1100, 4'b0000, 1'b1);
            else if (c < 8) apply(4'b1101, (b2 == 4) ? 4'b0100 : 4'b0000, 1'b1);
            else apply(4'b1101, 4'b1101, 1'b1);
            if (c < 8) check($sformatf("lock_c%0d_rdy", c), 64'(bus.usr_tx_ready), 64'b0100);
            else check("lock_next_owner_rdy", 64'(bus.usr_tx_ready), 64'b1000);
            if (c == 3 || c == 4 || c == 5)
                check($sformatf("lock_c%0d_vld", c), 64'(bus.rr_tx_valid), 64'd0);
            if (c == 8) begin
                check("lock_c8_tag", 64'(bus.rr_tx_tag), 64'd2);
                check("lock_c8_last", 64'(bus.rr_tx_last), 64'd1);
            end
            if (bus.usr_tx_valid[2] && bus.usr_tx_ready[2]) b2++;
            @(negedge clk);
        end
        check("lock_beats", 64'(b2), 64'd5);

        // Reset mid-batch: output dropped at once, first grant afterwards to user 0
        cfg_batch_size = 32'h04040404;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply(4'hF, 4'hF, 1'b1);
            @(negedge clk);
        end
        check("mid_pre_vld", 64'(bus.rr_tx_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(bus.rr_tx_valid), 64'd0);
        check("mid_rst_line", bus.rr_tx_line[63:0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'hF, 4'hF, 1'b1);
        check("mid_first_rdy", 64'(bus.usr_tx_ready), 64'b0001);
        check("mid_first_vld", 64'(bus.rr_tx_valid), 64'd0);
        @(negedge clk);
        apply(4'hF, 4'hF, 1'b1);
        check("mid_first_tag", 64'(bus.rr_tx_tag), 64'd0);
        check("mid_first_vld2", 64'(bus.rr_tx_valid), 64'd1);
        @(negedge clk);

        // Randomized packet traffic with random downstream back-pressure
        for (int r = 0; r < 4; r++) begin
            for (int u = 0; u < N; u++) begin
                pk_len[u] = 0;
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        pk_line[u][pk_len[u]] = 64'((r << 16) | (u << 8) | pk_len[u]);
                        pk_last[u][pk_len[u]] = (b == len - 1);
                        pk_len[u]++;
                    end
                end
            end
            for (int u = 0; u < N; u++) cfg_batch_size[u*BB +: BB] = BB'($urandom_range(0, 5));
            cfg_user_enable = 4'($urandom_range(1, 15));
            build_model(cfg_batch_size, cfg_user_enable);
            do_reset();
            foreach (ptr_r[i]) ptr_r[i] = 0;
            hold = 1'b0; hold_line = '0; cyc = 0; tail = 0;
            while (tail < 4) begin
                if (cyc > 3000) begin
                    check("rnd_timeout", 64'(cyc), 64'd0);
                    break;
                end
                for (int u = 0; u < N; u++) begin
                    bus.usr_tx_valid[u] = (ptr_r[u] < pk_len[u]);
                    bus.usr_tx_last[u]  = bus.usr_tx_valid[u] ? pk_last[u][ptr_r[u]] : 1'b0;
                    bus.usr_tx_lines[u] = bus.usr_tx_valid[u] ? W'(pk_line[u][ptr_r[u]]) : '0;
                end
                bus.rr_tx_ready = ($urandom_range(0, 3) != 0);
                #1;
                check("rnd_onehot_rdy", 64'($onehot0(bus.usr_tx_ready)), 64'd1);
                if (bus.rr_tx_valid && !bus.rr_tx_ready)
                    check("rnd_stall_rdy", 64'(bus.usr_tx_ready), 64'd0);
                if (hold) begin
                    check("rnd_hold_vld", 64'(bus.rr_tx_valid), 64'd1);
                    check("rnd_hold_line", bus.rr_tx_line[63:0], hold_line);
                end
                acc = bus.usr_tx_valid & bus.usr_tx_ready;
                if (bus.rr_tx_valid && bus.rr_tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_extra_beat", bus.rr_tx_line[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rnd_tag", 64'(bus.rr_tx_tag), 64'(e.tag));
                        check("rnd_line", bus.rr_tx_line[63:0], e.line);
                        check("rnd_last", 64'(bus.rr_tx_last), 64'(e.last));
                    end
                end
                hold      = bus.rr_tx_valid && !bus.rr_tx_ready;
                hold_line = bus.rr_tx_line[63:0];
                @(negedge clk);
                for (int u = 0; u < N; u++) if (acc[u]) ptr_r[u]++;
                if (exp_q.size() == 0) tail++;
                cyc++;
            end
            check($sformatf("rnd%0d_drained", r), 64'(exp_q.size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
